uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 67 ++++++
 tb/tb_uart_tx_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: two requester byte channels (valid/data/last/ready) feeding the UART arbiter
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with message lock feeding an 8N1 UART transmitter
module uart_tx_arbiter #(
    parameter int BAUD_PER = 10416
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    uart_tx_arbiter_if.slave   bus,
    output logic               tx,
    output logic [1:0]         grant,
    output logic               busy
);
    localparam int CW = $clog2(BAUD_PER + 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          locked;
    logic          last_srv;
    logic          tick;
    logic          pick1;
    logic          accept;

    // Requester selection, handshake and next-state decode
    always_comb begin
        pick1          = locked ? last_srv : (bus.req1_valid & (~bus.req0_valid | ~last_srv));
        accept         = nrst & en & (state == IDLE) & (pick1 ? bus.req1_valid : bus.req0_valid);
        bus.req0_ready = accept & ~pick1;
        bus.req1_ready = accept & pick1;
        tick           = baud_cnt == CW'(BAUD_PER);
        state_n        = (state == IDLE)  ? (accept ? START : IDLE) :
                         !tick            ? state :
                         (state == START) ? DATA :
                         (state == DATA)  ? ((bit_cnt == 3'd7) ? STOP : DATA) : IDLE;
    end

    // State, baud timing, shift register and arbitration memory
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            locked   <= 1'b0;
            last_srv <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + CW'(1);
            if (accept) begin
                shreg    <= pick1 ? bus.req1_data : bus.req0_data;
                last_srv <= pick1;
                locked   <= ~(pick1 ? bus.req1_last : bus.req0_last);
                bit_cnt  <= '0;
            end else if (state == DATA && tick) begin
                shreg    <= shreg >> 1;
                bit_cnt  <= bit_cnt + 3'd1;
            end
        end
    end

    assign tx    = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
    assign busy  = state != IDLE;
    assign grant = (locked | busy) ? (last_srv ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the UART arbiter with 4-cycle bits
module tb_uart_tx_arbiter;
    localparam int BP = 3;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       last;
    } item_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0;
    logic       tx;
    logic       busy;
    logic [1:0] grant;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.BAUD_PER(BP)) dut (
        .clk(clk), .nrst(nrst), .en(en), .bus(bus), .tx(tx), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    item_t      src0[$], src1[$], exp_acc[$];
    logic [7:0] exp_tx[$];
    int         acc_cyc[$];
    logic       acc_id[$];
    int         checks = 0, failures = 0, cyc = 0, rdy0_n = 0, rdy1_n = 0;
    logic       prev_tx = 1'b1, dec_on = 1'b0, dec_ab = 1'b0;
    int         dec_n = 0;
    logic [7:0] dec_sh = 8'h00;

    task automatic drive();
        bus.req0_valid = src0.size() > 0;
        bus.req0_data  = (src0.size() > 0) ? src0[0].data : 8'h00;
        bus.req0_last  = (src0.size() > 0) ? src0[0].last : 1'b0;
        bus.req1_valid = src1.size() > 0;
        bus.req1_data  = (src1.size() > 0) ? src1[0].data : 8'h00;
        bus.req1_last  = (src1.size() > 0) ? src1[0].last : 1'b0;
    endtask

    task automatic offer(input logic id, input logic [7:0] d, input logic l, input logic sent);
        item_t it;
        it.id = id;
        it.data = d;
        it.last = l;
        if (id) src1.push_back(it);
        else src0.push_back(it);
        exp_acc.push_back(it);
        if (sent) exp_tx.push_back(d);
    endtask

    // One clock: handshake scoreboard before the edge, serial decoder after it
    task automatic step();
        logic a0, a1, l;
        logic [7:0] d;
        item_t e;
        #1;
        a0 = bus.req0_ready & bus.req0_valid;
        a1 = bus.req1_ready & bus.req1_valid;
        rdy0_n += (bus.req0_ready === 1'b1) ? 1 : 0;
        rdy1_n += (bus.req1_ready === 1'b1) ? 1 : 0;
        checks++;
        if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin
            failures++;
            $display("FAIL one_ready: both readies high at cycle %0d, required at most one", cyc);
        end
        if (a0 === 1'b1 || a1 === 1'b1) begin
            checks++;
            d = a1 ? bus.req1_data : bus.req0_data;
            l = a1 ? bus.req1_last : bus.req0_last;
            if (exp_acc.size() == 0) begin
                failures++;
                $display("FAIL accept: req%0d byte %02h accepted at cycle %0d, none expected", a1, d, cyc);
            end else begin
                e = exp_acc.pop_front();
                if (e.id !== a1 || e.data !== d || e.last !== l) begin
                    failures++;
                    $display("FAIL accept: got req%0d %02h last=%0d, required req%0d %02h last=%0d",
                             a1, d, l, e.id, e.data, e.last);
                end
            end
            acc_cyc.push_back(cyc);
            acc_id.push_back(a1);
        end
        @(negedge clk);
        cyc++;
        if (a0 === 1'b1) src0.delete(0);
        if (a1 === 1'b1) src1.delete(0);
        if (dec_on) begin
            dec_n++;
            if (!nrst) dec_ab = 1'b1;
            if (dec_n % 4 == 2) begin
                if (dec_n / 4 == 0) begin
                    checks++;
                    if (tx !== 1'b0) begin
                        failures++;
                        $display("FAIL start_bit: tx=%b, required 0", tx);
                    end
                end else if (dec_n / 4 <= 8) begin
                    dec_sh[dec_n/4-1] = tx;
                end else begin
                    dec_on = 1'b0;
                    if (!dec_ab) begin
                        checks++;
                        if (tx !== 1'b1) begin
                            failures++;
                            $display("FAIL stop_bit: tx=%b, required 1", tx);
                        end
                        checks++;
                        if (exp_tx.size() == 0) begin
                            failures++;
                            $display("FAIL serial_byte: got %02h, no frame expected", dec_sh);
                        end else begin
                            d = exp_tx.pop_front();
                            if (dec_sh !== d) begin
                                failures++;
                                $display("FAIL serial_byte: got %02h, required %02h", dec_sh, d);
                            end
                        end
                    end
                end
            end
        end else if (prev_tx === 1'b1 && tx === 1'b0 && nrst === 1'b1) begin
            dec_on = 1'b1;
            dec_n  = 0;
            dec_ab = 1'b0;
        end
        prev_tx = tx;
        drive();
    endtask

    task automatic wait_acc(input int n);
        int t = 0;
        while (acc_cyc.size() < n && t < 400) begin
            step();
            t++;
        end
        checks++;
        if (acc_cyc.size() < n) begin
            failures++;
            $display("FAIL accept_timeout: %0d accepts, required %0d", acc_cyc.size(), n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((src0.size() > 0 || src1.size() > 0 || busy !== 1'b0 || dec_on) && t < 3000) begin
            step();
            t++;
        end
        checks++;
        if (t >= 3000) begin
            failures++;
            $display("FAIL idle_timeout: busy=%b pending=%0d/%0d", busy, src0.size(), src1.size());
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        en   = 1'b1;
        src0.delete();
        src1.delete();
        drive();
        step();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b, required 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: grant=%b, required 00", grant); end
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: ready=%b, required 00", {bus.req1_ready, bus.req0_ready});
        end
        nrst = 1'b1;
        drive();
    endtask

    task automatic test_single();
        int base, nb, r0;
        logic [9:0] got;
        test_reset();
        base = acc_cyc.size();
        r0 = rdy0_n;
        nb = 0;
        offer(1'b0, 8'hA5, 1'b1, 1'b1);
        drive();
        wait_acc(base + 1);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) nb++;
            if (i % 4 == 2) got[i/4] = tx;
            if (i == 20) begin
                checks++;
                if (grant !== 2'b01) begin failures++; $display("FAIL single_grant: grant=%b, required 01", grant); end
            end
            step();
        end
        checks++;
        if (rdy0_n - r0 !== 1) begin failures++; $display("FAIL single_ready: %0d ready cycles, required 1", rdy0_n - r0); end
        checks++;
        if (got !== 10'b1101001010) begin failures++; $display("FAIL single_bits: tx bits %b, required 1101001010", got); end
        checks++;
        if (nb !== 40) begin failures++; $display("FAIL single_busy: busy %0d cycles, required 40", nb); end
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL single_end: busy=%b grant=%b, required 0 00", busy, grant);
        end
    endtask

    task automatic test_contention();
        int base;
        test_reset();
        base = acc_cyc.size();
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 8'h10 + 8'(i), 1'b1, 1'b1);
            offer(1'b1, 8'hE0 + 8'(i), 1'b1, 1'b1);
        end
        drive();
        wait_acc(base + 6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc_id[base+i] !== 1'(i % 2)) begin
                failures++;
                $display("FAIL contention_order: accept %0d from req%0d, required req%0d", i, acc_id[base+i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (acc_cyc[base+i] - acc_cyc[base+i-1] !== 41) begin
                    failures++;
                    $display("FAIL contention_gap: spacing %0d, required 41", acc_cyc[base+i] - acc_cyc[base+i-1]);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_lock();
        int base, n, bad, t;
        test_reset();
        base = acc_cyc.size();
        bad = 0;
        t = 0;
        offer(1'b1, 8'h01, 1'b0, 1'b1);
        offer(1'b1, 8'h02, 1'b0, 1'b1);
        offer(1'b1, 8'h03, 1'b1, 1'b1);
        drive();
        step();
        offer(1'b0, 8'h77, 1'b1, 1'b1);
        drive();
        while (acc_cyc.size() - base < 4 && t < 600) begin
            step();
            t++;
            n = acc_cyc.size() - base;
            if (((n >= 1 && n < 3) || (n == 3 && busy === 1'b1)) && grant !== 2'b10) bad++;
        end
        checks++;
        if (acc_cyc.size() - base < 4) begin failures++; $display("FAIL lock_timeout: %0d accepts, required 4", acc_cyc.size() - base); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL lock_grant: %0d cycles with grant not 10, required 0", bad); end
        wait_idle();
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL lock_release: grant=%b, required 00", grant); end
    endtask

    task automatic test_en_gating();
        int base, badtx, t;
        test_reset();
        en = 1'b0;
        base = acc_cyc.size();
        badtx = 0;
        offer(1'b0, 8'h3C, 1'b1, 1'b1);
        offer(1'b1, 8'hC3, 1'b1, 1'b1);
        drive();
        repeat (100) begin
            step();
            if (tx !== 1'b1) badtx++;
        end
        checks++;
        if (acc_cyc.size() !== base) begin failures++; $display("FAIL en_off_accept: %0d accepts, required 0", acc_cyc.size() - base); end
        checks++;
        if (badtx !== 0) begin failures++; $display("FAIL en_off_tx: %0d cycles tx not 1, required 0", badtx); end
        en = 1'b1;
        wait_acc(base + 1);
        checks++;
        if (acc_id[base] !== 1'b0) begin failures++; $display("FAIL en_rise_pick: req%0d, required req0", acc_id[base]); end
        repeat (10) step();
        en = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 100) begin
            step();
            t++;
        end
        repeat (60) step();
        checks++;
        if (acc_cyc.size() !== base + 1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL en_drop: %0d accepts tx=%b, required 1 accept tx=1", acc_cyc.size() - base, tx);
        end
        en = 1'b1;
        wait_acc(base + 2);
        checks++;
        if (acc_id[base+1] !== 1'b1) begin failures++; $display("FAIL en_resume: req%0d, required req1", acc_id[base+1]); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int base, c;
        test_reset();
        base = acc_cyc.size();
        offer(1'b1, 8'h96, 1'b0, 1'b0);
        drive();
        wait_acc(base + 1);
        c = acc_cyc[base];
        while (cyc < c + 15) step();
        nrst = 1'b0;
        src0.delete();
        src1.delete();
        drive();
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset: tx=%b busy=%b grant=%b, required 1 0 00", tx, busy, grant);
        end
        nrst = 1'b1;
        repeat (45) step();
        offer(1'b0, 8'h5A, 1'b1, 1'b1);
        offer(1'b1, 8'h66, 1'b1, 1'b1);
        drive();
        wait_acc(base + 2);
        checks++;
        if (acc_id[base+1] !== 1'b0) begin failures++; $display("FAIL mid_reset_pick: req%0d, required req0", acc_id[base+1]); end
        wait_idle();
    endtask

    initial begin
        drive();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_en_gating();
        test_reset_mid();
        checks++;
        if (exp_acc.size() !== 0) begin failures++; $display("FAIL leftover_accepts: %0d pending, required 0", exp_acc.size()); end
        checks++;
        if (exp_tx.size() !== 0) begin failures++; $display("FAIL leftover_frames: %0d pending, required 0", exp_tx.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
